if_prefetch_buf: RTL and testbench
==================================

Name: if_prefetch_buf

Overview:
Instruction prefetch buffer between the fetch stage's instruction-memory request port and instruction memory.
- Serves fetch requests from a small FIFO of sequential instruction words.
- Keeps one memory read outstanding to refill the FIFO ahead of fetch.
- Handles redirects and kills from fetch by dropping stale words.
- Forwards memory access errors to fetch.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2.
XLEN, 32, address and instruction width.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high (asserted = 1)
if_req_i  input  1  fetch requests the instruction at if_addr_i
if_addr_i  input  XLEN  fetch PC; bits [1:0] ignored
if_kill_i  input  1  flush buffer, pause prefetch
if_ack_o  output  1  if_instr_o/if_err_o valid for if_addr_i this cycle
if_instr_o  output  XLEN  instruction word
if_err_o  output  1  access fault for this word
mem_req_o  output  1  memory read request
mem_addr_o  output  XLEN  word address; bits [1:0] = 0
mem_ack_i  input  1  one-cycle response; mem_rdata_i/mem_err_i valid
mem_rdata_i  input  XLEN  read data
mem_err_i  input  1  access fault

Behaviour:
- State: FIFO entries {instr, err}; count (0..DEPTH); head_pc; fetch_pc; pc_vld; halt; FSM {IDLE, BUSY, DRAIN}.
- Reset (async, rst_n = 1):
  - FIFO empty, pc_vld = 0, halt = 0, FSM = IDLE.
  - Outputs forced: mem_req_o = 0, mem_addr_o = 0, if_ack_o = 0, if_err_o = 0, if_instr_o = 0x00000013 (NOP).
  - Reset mid-transaction abandons the outstanding read; a late mem_ack_i after release is ignored because FSM = IDLE.
- Hit: if_req_i & count > 0 & if_addr_i[XLEN-1:2] == head_pc[XLEN-1:2].
  - Same cycle: if_ack_o = 1 combinationally, if_instr_o/if_err_o = head entry.
  - Pop; head_pc += 4.
  - Back-to-back sequential hits give one instruction per cycle.
- Miss: if_req_i & not hit & !if_kill_i.
  - if_ack_o = 0.
  - FIFO cleared; head_pc <= fetch_pc <= {if_addr_i[XLEN-1:2], 2'b00}; pc_vld <= 1; halt <= 0.
  - A miss while FIFO is empty and if_addr_i == fetch_pc with pc_vld = 1 is a wait, not a redirect: nothing is cleared.
- Empty output: if_instr_o = 0x00000013, if_err_o = 0 whenever count == 0.
- Memory protocol:
  - mem_req_o and mem_addr_o are held stable from assertion until the cycle mem_ack_i = 1.
  - At most one read is outstanding; a request cannot be aborted.
- FSM:
  - IDLE: if pc_vld & !halt & count < DEPTH & no redirect/kill this cycle, go BUSY with mem_addr_o = fetch_pc (mem_req_o asserts the next cycle).
  - BUSY, mem_ack_i = 1:
    - Push {mem_rdata_i, mem_err_i} at tail; fetch_pc += 4.
    - If mem_err_i, set halt and go IDLE.
    - Else if space remains after this cycle's push/pop, stay BUSY with the next address (back-to-back issue).
    - Else go IDLE.
  - BUSY, redirect or kill with no ack that cycle: go DRAIN, keeping the old mem_addr_o.
  - BUSY, redirect or kill in the same cycle as ack: data discarded, go IDLE.
  - DRAIN: hold the request until mem_ack_i, discard data, go IDLE; the new fetch_pc issues the following cycle.
- if_kill_i: FIFO cleared, pc_vld <= 0, no if_ack_o. Kill wins over a simultaneous if_req_i; that request is handled as a miss next cycle.
- Simultaneous pop and push: count unchanged. A full FIFO accepts a push only together with a pop.
- Latency: miss in cycle N, mem_req_o in N+1, ack in cycle M, if_ack_o in M+1 (entry becomes visible; no bypass).
- Arithmetic: fetch_pc and head_pc increment modulo 2^XLEN; 0xFFFFFFFC wraps to 0x00000000 and prefetch continues.
- Count width: $clog2(DEPTH+1).

Test Plan:
1. Reset, then if_req_i with addr 0x100; memory acks 2 cycles after each request, data = addr -> mem_req_o rises 1 cycle after the miss with mem_addr_o 0x100; if_ack_o 1 cycle after the ack with instr 0x100. With fetch held, prefetch of 0x104..0x110 stops once count = 4; mem_req_o stays 0.
2. FIFO full (0x104..0x110), requests 0x104, 0x108, 0x10C, 0x110 on consecutive cycles -> if_ack_o = 1 every cycle with matching data; refills of 0x114.. issue.
3. Read of 0x114 outstanding, fetch requests 0x200 -> mem_addr_o stays 0x114 until ack; that data is never delivered; next mem_addr_o = 0x200; first if_ack_o carries 0x200.
4. mem_err_i = 1 on 0x10C -> request for 0x10C acked with if_err_o = 1; no mem request for 0x110 until a redirect to 0x300, which resumes prefetch at 0x300.
5. Request 0xFFFFFFF8 -> prefetch addresses 0xFFFFFFFC then 0x00000000; sequential hits return correct data across the wrap.
6. if_kill_i in the same cycle as mem_ack_i -> count = 0, if_ack_o = 0, mem_req_o stays 0 until the next if_req_i. Separately, rst_n asserted mid-BUSY -> mem_req_o = 0 in the same cycle, before the next clock edge.

Source files
------------

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: serves sequential fetches from a small FIFO refilled by a
// single-outstanding memory read port; redirects and kills drop stale words.
module if_prefetch_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    input  logic            if_kill_i,
    output logic            if_ack_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic            if_err_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  head_pc_q, fetch_pc_q;
    logic             pc_vld_q, halt_q;
    state_e           state_q;
    logic             mem_req_q;
    logic [XLEN-1:0]  mem_addr_q;

    logic             empty, hit, wait_pc, redirect, flush, push, pop, space_nxt;
    logic [XLEN-1:0]  new_pc;
    logic [CNT_W-1:0] count_nxt;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^if_addr_i[1:0];

    assign empty    = (count_q == '0);
    assign hit      = if_req_i & ~if_kill_i & ~empty
                      & (if_addr_i[XLEN-1:2] == head_pc_q[XLEN-1:2]);
    // Empty buffer already fetching the requested word: keep waiting, do not restart.
    assign wait_pc  = empty & pc_vld_q & (if_addr_i[XLEN-1:2] == fetch_pc_q[XLEN-1:2]);
    assign redirect = if_req_i & ~if_kill_i & ~hit & ~wait_pc;
    assign flush    = redirect | if_kill_i;
    assign new_pc   = {if_addr_i[XLEN-1:2], 2'b00};

    assign push      = (state_q == StBusy) & mem_ack_i & ~flush;
    assign pop       = hit;
    assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
    assign space_nxt = (count_nxt < CNT_W'(DEPTH));

    assign if_ack_o   = hit;
    assign if_instr_o = empty ? NOP : instr_q[rd_ptr_q];
    assign if_err_o   = ~empty & err_q[rd_ptr_q];
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= mem_rdata_i;
            err_q[wr_ptr_q]   <= mem_err_i;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_pc_q  <= '0;
            fetch_pc_q <= '0;
            pc_vld_q   <= 1'b0;
            halt_q     <= 1'b0;
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                if (redirect) begin
                    head_pc_q  <= new_pc;
                    fetch_pc_q <= new_pc;
                    pc_vld_q   <= 1'b1;
                    halt_q     <= 1'b0;
                end else begin
                    pc_vld_q <= 1'b0;
                end
            end else begin
                count_q <= count_nxt;
                if (pop) begin
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    head_pc_q <= head_pc_q + XLEN'(4);
                end
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                    if (mem_err_i) halt_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    // A redirect is issued straight away with the new PC.
                    if (redirect) begin
                        state_q    <= StBusy;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= new_pc;
                    end else if (!if_kill_i && pc_vld_q && !halt_q
                                 && count_q < CNT_W'(DEPTH)) begin
                        state_q    <= StBusy;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                StBusy: begin
                    if (mem_ack_i) begin
                        if (flush || mem_err_i || !space_nxt) begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end else begin
                            mem_addr_q <= fetch_pc_q + XLEN'(4);
                        end
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (mem_ack_i) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Self-checking bench for if_prefetch_buf: directed table and sequences, then random fetch
// traffic scored against a word-by-address memory model.
module tb_if_prefetch_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_kill_i = 1'b0;
    logic        if_ack_o;
    logic [31:0] if_instr_o;
    logic        if_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model knobs
    int          mem_lat = 2;
    bit          rand_lat = 1'b0;
    logic [31:0] data_xor = '0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] issued[$];

    if_prefetch_buf #(.DEPTH(4), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_kill_i  (if_kill_i),
        .if_ack_o   (if_ack_o),
        .if_instr_o (if_instr_o),
        .if_err_o   (if_err_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .mem_err_i  (mem_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until acked or max cycles pass; lat = cycles waited before the ack.
    task automatic fetch(input logic [31:0] a, input int max, output bit ok,
                         output logic [31:0] ins, output logic er, output int lat);
        ok = 1'b0; ins = '0; er = 1'b0; lat = 0;
        if_req_i = 1'b1;
        if_addr_i = a;
        while (!ok && lat < max) begin
            @(negedge clk);
            if (if_ack_o) begin
                ok = 1'b1; ins = if_instr_o; er = if_err_o;
            end else begin
                lat++;
            end
            tick();
        end
        if_req_i = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] a, input logic exp_err);
        bit ok; logic [31:0] ins; logic er; int lat;
        fetch(a, 60, ok, ins, er, lat);
        chk1({name, "_acked"}, ok, 1'b1);
        chk({name, "_instr"}, ins, a ^ data_xor);
        chk1({name, "_err"}, er, exp_err);
    endtask

    // Memory: acks lat cycles after seeing a request; data = addr ^ data_xor.
    initial begin : responder
        bit busy, abandoned;
        int cd;
        logic [31:0] addr;
        busy = 1'b0; abandoned = 1'b0; cd = 0; addr = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        forever begin
            tick();
            mem_ack_i = 1'b0;
            mem_err_i = 1'b0;
            if (rst_n && busy) abandoned = 1'b1;
            if (busy) begin
                if (!abandoned) begin
                    chk1("mem_req_held", mem_req_o, 1'b1);
                    chk("mem_addr_held", mem_addr_o, addr);
                end
                if (cd == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = addr ^ data_xor;
                    mem_err_i   = err_en && (addr == err_addr);
                    busy = 1'b0;
                    abandoned = 1'b0;
                end else begin
                    cd--;
                end
            end else if (!rst_n && mem_req_o) begin
                busy = 1'b1;
                addr = mem_addr_o;
                issued.push_back(addr);
                cd = (rand_lat ? int'($urandom_range(1, 4)) : mem_lat) - 1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          kill;
        bit          exp_ack;
        logic [31:0] exp_instr;
    } vec_t;

    initial begin : main
        vec_t vecs[5];
        bit ok, found;
        logic [31:0] ins, first, seen_addr, pc;
        logic er;
        int lat, idx, waitc;
        bit r_req, r_kill;

        vecs[0] = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h104};
        vecs[1] = '{1'b1, 32'h108, 1'b0, 1'b1, 32'h108};
        vecs[2] = '{1'b1, 32'h10C, 1'b0, 1'b1, 32'h10C};
        vecs[3] = '{1'b1, 32'h110, 1'b0, 1'b1, 32'h110};
        vecs[4] = '{1'b0, 32'h0,   1'b0, 1'b0, NOP};

        // Reset state
        @(negedge clk);
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk1("rst_if_ack", if_ack_o, 1'b0);
        chk1("rst_if_err", if_err_o, 1'b0);
        chk("rst_if_instr", if_instr_o, NOP);
        @(negedge clk);
        rst_n = 1'b0;
        tick();

        // 1: miss, request latency, fill until full
        if_req_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk);
        chk1("t1_miss_no_ack", if_ack_o, 1'b0);
        tick();
        @(negedge clk);
        chk1("t1_req_next_cycle", mem_req_o, 1'b1);
        chk("t1_req_addr", mem_addr_o, 32'h100);
        tick();
        fetch(32'h100, 20, ok, ins, er, lat);
        chk1("t1_acked", ok, 1'b1);
        chk("t1_instr", ins, 32'h100);
        chk("t1_ack_latency", 32'(lat), 32'd2);
        repeat (20) tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("t1_full_no_req", mem_req_o, 1'b0);
            tick();
        end

        // 2: back-to-back hits from a full buffer
        mem_lat = 6;
        for (int i = 0; i < 5; i++) begin
            if_req_i = vecs[i].req; if_addr_i = vecs[i].addr; if_kill_i = vecs[i].kill;
            @(negedge clk);
            chk1($sformatf("t2_vec%0d_ack", i), if_ack_o, vecs[i].exp_ack);
            chk($sformatf("t2_vec%0d_instr", i), if_instr_o, vecs[i].exp_instr);
            tick();
        end
        if_req_i = 1'b0; if_kill_i = 1'b0;
        found = 1'b0; seen_addr = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_req_o) begin found = 1'b1; seen_addr = mem_addr_o; end
            tick();
        end
        chk1("t2_refill_issued", found, 1'b1);
        chk("t2_refill_addr", seen_addr, 32'h114);

        // 3: redirect while 0x114 is outstanding
        issued.delete();
        fetch(32'h200, 60, ok, ins, er, lat);
        chk1("t3_acked", ok, 1'b1);
        chk("t3_instr", ins, 32'h200);
        first = (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF;
        chk("t3_next_mem_addr", first, 32'h200);

        // 4: access fault halts prefetch until a redirect
        mem_lat = 1; err_addr = 32'h10C; err_en = 1'b1;
        fetch_chk("t4_100", 32'h100, 1'b0);
        fetch_chk("t4_104", 32'h104, 1'b0);
        fetch_chk("t4_108", 32'h108, 1'b0);
        fetch_chk("t4_10c", 32'h10C, 1'b1);
        issued.delete();
        fetch(32'h110, 20, ok, ins, er, lat);
        chk1("t4_halted_no_ack", ok, 1'b0);
        chk("t4_halted_no_issue", 32'(issued.size()), 32'd0);
        chk1("t4_halted_req_low", mem_req_o, 1'b0);
        fetch_chk("t4_300", 32'h300, 1'b0);
        err_en = 1'b0;

        // 5: address wrap
        mem_lat = 2;
        issued.delete();
        fetch_chk("t5_fff8", 32'hFFFF_FFF8, 1'b0);
        fetch_chk("t5_fffc", 32'hFFFF_FFFC, 1'b0);
        fetch_chk("t5_0000", 32'h0000_0000, 1'b0);
        fetch_chk("t5_0004", 32'h0000_0004, 1'b0);
        idx = -1;
        foreach (issued[i]) if (idx < 0 && issued[i] == 32'hFFFF_FFF8) idx = i;
        chk1("t5_found_fff8", idx >= 0, 1'b1);
        chk("t5_issue_fffc", (idx >= 0 && idx + 1 < issued.size()) ? issued[idx+1] : 32'hDEAD_BEEF,
            32'hFFFF_FFFC);
        chk("t5_issue_0000", (idx >= 0 && idx + 2 < issued.size()) ? issued[idx+2] : 32'hDEAD_BEEF,
            32'h0000_0000);

        // 6a: kill in the same cycle as a memory ack
        fetch_chk("t6_400", 32'h400, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_ack_i) found = 1'b1;
            else tick();
        end
        chk1("t6_ack_seen", found, 1'b1);
        if_kill_i = 1'b1;
        #1;
        chk1("t6_kill_no_ack", if_ack_o, 1'b0);
        tick();
        if_kill_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("t6_killed_no_req", mem_req_o, 1'b0);
            chk("t6_killed_empty", if_instr_o, NOP);
            tick();
        end

        // 6b: kill beats a request that would hit
        fetch_chk("t6_500", 32'h500, 1'b0);
        repeat (10) tick();
        if_req_i = 1'b1; if_addr_i = 32'h504; if_kill_i = 1'b1;
        @(negedge clk);
        chk1("t6_kill_wins", if_ack_o, 1'b0);
        tick();
        if_kill_i = 1'b0;
        fetch_chk("t6_504", 32'h504, 1'b0);

        // 6c: reset during an outstanding read
        mem_lat = 5;
        fetch_chk("t6_600", 32'h600, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_req_o) found = 1'b1;
            else tick();
        end
        chk1("t6_busy_before_rst", found, 1'b1);
        rst_n = 1'b1;
        #1;
        chk1("t6_rst_req_low", mem_req_o, 1'b0);
        chk("t6_rst_addr", mem_addr_o, 32'h0);
        chk("t6_rst_instr", if_instr_o, NOP);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("t6_late_ack_no_req", mem_req_o, 1'b0);
            chk("t6_late_ack_empty", if_instr_o, NOP);
            tick();
        end
        fetch_chk("t6_700", 32'h700, 1'b0);

        // Random traffic: every delivered word must be the memory word for the requested PC
        rand_lat = 1'b1;
        data_xor = 32'hA5A5_0000;
        pc = 32'h1000;
        waitc = 0;
        for (int c = 0; c < 3000; c++) begin
            r_req  = ($urandom_range(0, 4) != 0);
            r_kill = ($urandom_range(0, 40) == 0);
            if_req_i = r_req; if_kill_i = r_kill;
            if_addr_i = pc | 32'($urandom_range(0, 3));
            @(negedge clk);
            if (if_ack_o) begin
                chk1("rand_ack_legal", r_req && !r_kill, 1'b1);
                chk("rand_instr", if_instr_o, pc ^ data_xor);
                chk1("rand_err", if_err_o, 1'b0);
                waitc = 0;
                case ($urandom_range(0, 9))
                    8:       pc = 32'h2000 + 32'($urandom_range(0, 63)) * 4;
                    9:       pc = pc - 32'd12;
                    default: pc = pc + 32'd4;
                endcase
            end else if (r_req) begin
                waitc++;
                if (waitc > 80) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_progress: pc 0x%08h not acked after %0d cycles, required <= 80",
                             pc, waitc);
                    waitc = 0;
                    pc = pc + 32'h100;
                end
            end
            tick();
        end
        if_req_i = 1'b0; if_kill_i = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
